gpr_dump: RTL and testbench

Sequential reader for the general-purpose register file: on a `start` pulse it walks register addresses 0..NUM_REGS-1 through one register-file read port and streams each captured word out over a valid/ready interface. It sits beside the register file, driving one read-address port and consuming the matching read-data port. It feeds debug/trace logic that needs a full register snapshot without stalling the datapath's write port.

---
 rtl/gpr_dump_if.sv | 17 +
 rtl/gpr_dump.sv | 119 +++++++++++
 tb/tb_gpr_dump.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/gpr_dump_if.sv
// gpr_dump_if: control, register-file read port and valid/ready output stream of gpr_dump.
interface gpr_dump_if #(parameter int DATA_W = 16, parameter int ADDR_W = 4);
  logic              start;
  logic              busy;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_last;
  logic              done;
  modport master (input start, rd_data, out_ready,
                  output busy, rd_addr, out_valid, out_data, out_index, out_last, done);
  modport slave  (output start, rd_data, out_ready,
                  input busy, rd_addr, out_valid, out_data, out_index, out_last, done);
endinterface

// File: rtl/gpr_dump.sv
// gpr_dump: walks register addresses 0..NUM_REGS-1 and streams each word over valid/ready.
// Defining GPR_DUMP_CHECKSUM_EN appends a sum-of-words word with index NUM_REGS.
module gpr_dump #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4
) (
  input logic        clk,
  input logic        reset,
  gpr_dump_if.master bus
);
`ifdef GPR_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, READ, SEND, CKSUM, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;
`endif
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] out_index_q, out_index_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              hs;
`ifdef GPR_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
`endif
  assign hs = out_valid_q && bus.out_ready;
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_index_d = out_index_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
`ifdef GPR_DUMP_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    unique case (state_q)
      IDLE: if (bus.start) begin
        state_d = READ;
        idx_d   = '0;
`ifdef GPR_DUMP_CHECKSUM_EN
        sum_d   = '0;
`endif
      end
      READ: begin
        state_d     = SEND;
        out_valid_d = 1'b1;
        out_data_d  = bus.rd_data;
        out_index_d = idx_q;
`ifdef GPR_DUMP_CHECKSUM_EN
        out_last_d  = 1'b0;
        sum_d       = sum_q + bus.rd_data;
`else
        out_last_d  = idx_q == LAST;
`endif
      end
      SEND: if (hs) begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        idx_d       = idx_q + 1'b1;
        state_d     = READ;
        if (idx_q == LAST) begin
          idx_d = '0;
`ifdef GPR_DUMP_CHECKSUM_EN
          // checksum word is presented straight from the accumulator, no READ cycle
          state_d     = CKSUM;
          out_valid_d = 1'b1;
          out_data_d  = sum_q;
          out_index_d = ADDR_W'(NUM_REGS);
          out_last_d  = 1'b1;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef GPR_DUMP_CHECKSUM_EN
      CKSUM: if (hs) begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        state_d     = DONE;
      end
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      out_index_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
`ifdef GPR_DUMP_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_index_q <= out_index_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
`ifdef GPR_DUMP_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end
  assign bus.busy      = state_q != IDLE;
  assign bus.rd_addr   = idx_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_index = out_index_q;
  assign bus.out_last  = out_last_q;
  assign bus.done      = state_q == DONE;
endmodule

// File: tb/tb_gpr_dump.sv
// tb_gpr_dump: directed bench for gpr_dump; register file modelled here with one write port.
module tb_gpr_dump;
`ifdef GPR_DUMP_CHECKSUM_EN
  localparam int NW = 9;
`else
  localparam int NW = 8;
`endif
  logic clk = 1'b0;
  logic reset;
  logic we;
  logic [2:0] wa;
  logic [15:0] wd;
  logic [15:0] regs [8];
  logic [15:0] exp_mem [8];
  int checks = 0;
  int errors = 0;
  gpr_dump_if #(.DATA_W(16), .ADDR_W(4)) bus ();
  gpr_dump #(.NUM_REGS(8), .DATA_W(16), .ADDR_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always_ff @(posedge clk) if (we) regs[wa] <= wd;
  assign bus.rd_data = regs[bus.rd_addr[2:0]];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_rd_addr"}, 32'(bus.rd_addr), 0);
    chk({tag, "_valid"}, 32'(bus.out_valid), 0);
    chk({tag, "_data"}, 32'(bus.out_data), 0);
    chk({tag, "_index"}, 32'(bus.out_index), 0);
    chk({tag, "_last"}, 32'(bus.out_last), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
  endtask
  // Called at a negedge with the DUT idle; returns at the negedge after done has dropped.
  task automatic dump(input bit rnd, input int busy_start_t, input int wr_t, input logic [15:0] wr_val);
    int t = 0;
    int k = 0;
    int hs_t = -1;
    logic stalled = 1'b0;
    logic [15:0] sd = '0;
    logic [3:0] si = '0;
    logic [15:0] sum = '0;
    bus.start = 1'b1;
    while (k < NW && t < 400) begin
      @(negedge clk);
      t++;
      bus.start = (t == busy_start_t);
      we = (t == wr_t);
      wa = 3'd5;
      wd = wr_val;
      if (t == 1) begin
        chk("busy_after_start", 32'(bus.busy), 1);
        chk("valid_in_first_read", 32'(bus.out_valid), 0);
      end
      if (stalled) begin
        chk("stall_valid", 32'(bus.out_valid), 1);
        chk("stall_data", 32'(bus.out_data), 32'(sd));
        chk("stall_index", 32'(bus.out_index), 32'(si));
      end
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = bus.out_valid && !bus.out_ready;
      sd = bus.out_data;
      si = bus.out_index;
      if (bus.out_valid && bus.out_ready) begin
        chk("word_data", 32'(bus.out_data), 32'((k < 8) ? exp_mem[k] : sum));
        chk("word_index", 32'(bus.out_index), 32'(k));
        chk("word_last", 32'(bus.out_last), 32'(k == NW - 1));
        if (k < 8) sum = sum + exp_mem[k];
        hs_t = t;
        k++;
      end
    end
    bus.start = 1'b0;
    we = 1'b0;
    chk("word_count", 32'(k), 32'(NW));
    if (!rnd) chk("last_handshake_cycle", 32'(hs_t), 32'(NW == 9 ? 17 : 16));
    @(negedge clk);
    chk("done_pulse", 32'(bus.done), 1);
    chk("valid_at_done", 32'(bus.out_valid), 0);
    @(negedge clk);
    chk("done_cleared", 32'(bus.done), 0);
    chk("idle_after_done", 32'(bus.busy), 0);
  endtask
  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    we = 1'b0;
    wa = '0;
    wd = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      we = 1'b1;
      wa = 3'(i);
      wd = 16'h1000 + 16'(i);
      exp_mem[i] = 16'h1000 + 16'(i);
    end
    @(negedge clk);
    we = 1'b0;
    @(negedge clk);
    chk_idle("reset");
    reset = 1'b0;
    @(negedge clk);
    chk_idle("post_reset");
    // plain dump, ready held high
    dump(1'b0, 0, 0, 16'h0);
`ifdef GPR_DUMP_CHECKSUM_EN
    chk("cksum_hand_value", 32'(exp_mem[0] + exp_mem[1] + exp_mem[2] + exp_mem[3] +
        exp_mem[4] + exp_mem[5] + exp_mem[6] + exp_mem[7]), 32'h801C);
`endif
    // random back-pressure
    dump(1'b1, 0, 0, 16'h0);
    dump(1'b1, 0, 0, 16'h0);
    // start while busy is ignored, then an immediate second dump
    dump(1'b0, 6, 0, 16'h0);
    repeat (3) @(negedge clk);
    chk("no_queued_start", 32'(bus.busy), 0);
    dump(1'b0, 0, 0, 16'h0);
    // reset while index 3 is stalled in SEND
    bus.start = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.out_valid && bus.out_index == 4'd3) begin
        bus.out_ready = 1'b0;
        break;
      end
    end
    chk("stall_idx3_reached", 32'(bus.out_index), 3);
    @(negedge clk);
    chk("stall_idx3_held", 32'(bus.out_valid), 1);
    reset = 1'b1;
    @(negedge clk);
    chk_idle("mid_reset");
    reset = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    dump(1'b0, 0, 0, 16'h0);
    // write r5 on the capture edge of index 5: old value is streamed
    dump(1'b0, 0, 11, 16'hBEEF);
    exp_mem[5] = 16'hBEEF;
    dump(1'b0, 0, 0, 16'h0);
    // write r5 one edge before its READ cycle: new value is streamed
    exp_mem[5] = 16'hCAFE;
    dump(1'b0, 0, 10, 16'hCAFE);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
